// File: rtl/branch_presolve_nwide_if.sv
// branch_presolve_nwide_if: fetch pack in, redirect out, handshakes for the pre-resolver
interface branch_presolve_nwide_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int XLEN = 64
);
    localparam int SW = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1;
    logic flush;
    logic fetch_valid;
    logic fetch_ready;
    logic [FETCH_WIDTH-1:0] fetch_valids;
    logic [XLEN-1:0] fetch_pc;
    logic [32*FETCH_WIDTH-1:0] fetch_insts;
    logic pred_valid;
    logic [SW-1:0] pred_select;
    logic pred_taken;
    logic [XLEN-1:0] pred_target;
    logic redirect_valid;
    logic redirect_ready;
    logic redirect_taken;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0] redirect_kind;
    logic [SW-1:0] redirect_slot;
    logic [31:0] redirect_count;
    modport slave (
        input flush, fetch_valid, fetch_valids, fetch_pc, fetch_insts,
        input pred_valid, pred_select, pred_taken, pred_target, redirect_ready,
        output fetch_ready, redirect_valid, redirect_taken, redirect_pc,
        output redirect_kind, redirect_slot, redirect_count
    );
    modport master (
        output flush, fetch_valid, fetch_valids, fetch_pc, fetch_insts,
        output pred_valid, pred_select, pred_taken, pred_target, redirect_ready,
        input fetch_ready, redirect_valid, redirect_taken, redirect_pc,
        input redirect_kind, redirect_slot, redirect_count
    );
endinterface

// File: rtl/branch_presolve_nwide.sv
// branch_presolve_nwide: predecodes an N-wide fetch pack and issues registered predictor corrections
module branch_presolve_nwide #(
    parameter int FETCH_WIDTH = 2,
    parameter int XLEN = 64
) (
    input logic clock,
    input logic reset,
    branch_presolve_nwide_if.slave bus
);
    localparam int SW = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1;
    localparam int AB = $clog2(4 * FETCH_WIDTH);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] slot_pc [FETCH_WIDTH];
    logic [XLEN-1:0] slot_tgt [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] is_jal;
    logic [FETCH_WIDTH-1:0] is_ctl;
    logic has_pred;
    logic accept;
    logic hit;
    logic done;
    logic [1:0] kind;
    logic [XLEN-1:0] rpc;
    logic rtk;
    logic [SW-1:0] rslot;
    logic taken_q;
    logic [XLEN-1:0] pc_q;
    logic [1:0] kind_q;
    logic [SW-1:0] slot_q;
    logic [31:0] count;

    assign base = bus.fetch_pc & ~((XLEN'(1) << AB) - XLEN'(1));
    assign has_pred = bus.pred_valid & bus.pred_taken;
    assign bus.fetch_ready = !reset & !bus.flush & (state == EMPTY | bus.redirect_ready);
    assign accept = bus.fetch_valid & bus.fetch_ready;

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
        logic [31:0] inst;
        logic unused_rd;
        assign inst = bus.fetch_insts[32*i +: 32];
        assign unused_rd = ^inst[11:7];
        assign slot_pc[i] = base + XLEN'(4 * i);
        assign slot_tgt[i] = slot_pc[i] + {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        assign is_jal[i] = bus.fetch_valids[i] & (inst[6:0] == 7'b1101111);
        assign is_ctl[i] = bus.fetch_valids[i] & (inst[6:0] == 7'b1100011 | inst[6:0] == 7'b1101111 | inst[6:0] == 7'b1100111);
    end

    // First-hit scan up to the predicted slot; the predicted slot always ends the scan
    always_comb begin
        hit = 1'b0;
        done = 1'b0;
        kind = 2'd0;
        rpc = '0;
        rtk = 1'b0;
        rslot = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (!done) begin
                if (has_pred && SW'(k) == bus.pred_select) begin
                    done = 1'b1;
                    if (!is_ctl[k]) begin
                        hit = 1'b1;
                        kind = 2'd1;
                        rpc = base + ((XLEN'(bus.pred_select) + XLEN'(1)) << 2);
                        rslot = bus.pred_select;
                    end else if (is_jal[k] && slot_tgt[k] != bus.pred_target) begin
                        hit = 1'b1;
                        kind = 2'd3;
                        rpc = slot_tgt[k];
                        rtk = 1'b1;
                        rslot = bus.pred_select;
                    end
                end else if (is_jal[k]) begin
                    done = 1'b1;
                    hit = 1'b1;
                    kind = 2'd2;
                    rpc = slot_tgt[k];
                    rtk = 1'b1;
                    rslot = SW'(k);
                end
            end
        end
    end

    // One-entry output register, EMPTY/FULL state and saturating redirect counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
            taken_q <= 1'b0;
            pc_q <= '0;
            kind_q <= 2'd0;
            slot_q <= '0;
            count <= 32'd0;
        end else if (bus.flush) begin
            state <= EMPTY;
        end else if (accept && hit) begin
            state <= FULL;
            taken_q <= rtk;
            pc_q <= rpc;
            kind_q <= kind;
            slot_q <= rslot;
            count <= count + {31'd0, count != 32'hFFFF_FFFF};
        end else if (state == FULL && bus.redirect_ready) begin
            state <= EMPTY;
        end
    end

    assign bus.redirect_valid = state == FULL;
    assign bus.redirect_taken = taken_q;
    assign bus.redirect_pc = pc_q;
    assign bus.redirect_kind = kind_q;
    assign bus.redirect_slot = slot_q;
    assign bus.redirect_count = count;
endmodule

// File: tb/tb_branch_presolve_nwide.sv
// tb_branch_presolve_nwide: directed scenarios for the fetch-stage pre-resolver
module tb_branch_presolve_nwide;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    always #5 clock = ~clock;

    branch_presolve_nwide_if #(.FETCH_WIDTH(2), .XLEN(64)) b ();
    branch_presolve_nwide_if #(.FETCH_WIDTH(4), .XLEN(64)) b4 ();
    branch_presolve_nwide #(.FETCH_WIDTH(2), .XLEN(64)) dut (.clock(clock), .reset(reset), .bus(b));
    branch_presolve_nwide #(.FETCH_WIDTH(4), .XLEN(64)) dut4 (.clock(clock), .reset(reset), .bus(b4));

    wire [68:0] obs = {b.redirect_valid, b.redirect_taken, b.redirect_kind, b.redirect_slot, b.redirect_pc};
    wire [69:0] obs4 = {b4.redirect_valid, b4.redirect_taken, b4.redirect_kind, b4.redirect_slot, b4.redirect_pc};

    task step;
        @(posedge clock);
        #1;
    endtask

    task idle;
        b.flush = 0; b.fetch_valid = 0; b.fetch_valids = 0; b.fetch_pc = 0; b.fetch_insts = 0;
        b.pred_valid = 0; b.pred_select = 0; b.pred_taken = 0; b.pred_target = 0; b.redirect_ready = 1;
        b4.flush = 0; b4.fetch_valid = 0; b4.fetch_valids = 0; b4.fetch_pc = 0; b4.fetch_insts = 0;
        b4.pred_valid = 0; b4.pred_select = 0; b4.pred_taken = 0; b4.pred_target = 0; b4.redirect_ready = 1;
    endtask

    task offer(input logic [63:0] pc, input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] v,
               input logic pv, input logic tk, input logic sel, input logic [63:0] tgt);
        b.fetch_valid = 1; b.fetch_pc = pc; b.fetch_insts = {i1, i0}; b.fetch_valids = v;
        b.pred_valid = pv; b.pred_taken = tk; b.pred_select = sel; b.pred_target = tgt;
    endtask

    task fire;
        step;
        b.fetch_valid = 0;
    endtask

    task test_reset;
        idle;
        step; step;
        checks++; if (b.fetch_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", b.fetch_ready); end
        reset = 0;
        #1;
        checks++; if (b.fetch_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b want 1", b.fetch_ready); end
        checks++; if (obs !== 69'd0) begin errors++; $display("FAIL rst_out got %h want 0", obs); end
        checks++; if (b.redirect_count !== 32'd0) begin errors++; $display("FAIL rst_count got %h want 0", b.redirect_count); end
    endtask

    task test_false_taken;
        offer(64'h8000_0004, 32'h33, 32'h33, 2'b11, 1, 1, 1, 0);
        fire;
        exp_cnt = 1;
        checks++; if (obs !== {1'b1, 1'b0, 2'd1, 1'b1, 64'h8000_0008}) begin errors++; $display("FAIL ft_out got %h want 1_0_1_1_80000008", obs); end
        checks++; if (b.redirect_count !== exp_cnt) begin errors++; $display("FAIL ft_count got %h want %h", b.redirect_count, exp_cnt); end
        step;
        checks++; if (b.redirect_valid !== 1'b0) begin errors++; $display("FAIL ft_consumed got %b want 0", b.redirect_valid); end
        offer(64'h1000, 32'h33, 32'h0100_006f, 2'b01, 1, 1, 1, 0);
        fire;
        exp_cnt = 2;
        checks++; if (obs !== {1'b1, 1'b0, 2'd1, 1'b1, 64'h1008}) begin errors++; $display("FAIL ft_invalid got %h want 1_0_1_1_1008", obs); end
        step;
        b4.fetch_valid = 1; b4.fetch_pc = 64'h1000; b4.fetch_insts = {4{32'h33}}; b4.fetch_valids = 4'hf;
        b4.pred_valid = 1; b4.pred_taken = 1; b4.pred_select = 2'd3;
        step;
        b4.fetch_valid = 0;
        checks++; if (obs4 !== {1'b1, 1'b0, 2'd1, 2'd3, 64'h1010}) begin errors++; $display("FAIL ft_w4 got %h want 1_0_1_3_1010", obs4); end
        checks++; if (b4.redirect_count !== 32'd1) begin errors++; $display("FAIL ft_w4_count got %h want 1", b4.redirect_count); end
    endtask

    task test_jal_missed;
        offer(64'h1000, 32'h0100_006f, 32'h33, 2'b11, 0, 0, 0, 0);
        fire;
        exp_cnt = 3;
        checks++; if (obs !== {1'b1, 1'b1, 2'd2, 1'b0, 64'h1010}) begin errors++; $display("FAIL jm_fwd got %h want 1_1_2_0_1010", obs); end
        offer(64'h1000, 32'hffdf_f06f, 32'h33, 2'b11, 1, 1, 1, 0);
        fire;
        exp_cnt = 4;
        checks++; if (obs !== {1'b1, 1'b1, 2'd2, 1'b0, 64'h0ffc}) begin errors++; $display("FAIL jm_back got %h want 1_1_2_0_ffc", obs); end
        offer(64'h1004, 32'h33, 32'h0080_006f, 2'b11, 0, 0, 0, 0);
        fire;
        exp_cnt = 5;
        checks++; if (obs !== {1'b1, 1'b1, 2'd2, 1'b1, 64'h100c}) begin errors++; $display("FAIL jm_slot1 got %h want 1_1_2_1_100c", obs); end
        checks++; if (b.redirect_count !== exp_cnt) begin errors++; $display("FAIL jm_count got %h want %h", b.redirect_count, exp_cnt); end
    endtask

    task test_no_redirect;
        offer(64'h1000, 32'h63, 32'h0080_006f, 2'b11, 1, 1, 0, 0);
        fire;
        checks++; if (b.redirect_valid !== 1'b0) begin errors++; $display("FAIL nr_after_s got %b want 0", b.redirect_valid); end
        offer(64'h1000, 32'h33, 32'h33, 2'b11, 1, 0, 0, 0);
        fire;
        checks++; if (b.redirect_valid !== 1'b0) begin errors++; $display("FAIL nr_not_taken got %b want 0", b.redirect_valid); end
        offer(64'h1000, 32'h33, 32'h63, 2'b11, 1, 1, 1, 0);
        fire;
        checks++; if (b.redirect_valid !== 1'b0) begin errors++; $display("FAIL nr_beq got %b want 0", b.redirect_valid); end
        checks++; if (b.fetch_ready !== 1'b1) begin errors++; $display("FAIL nr_ready got %b want 1", b.fetch_ready); end
        offer(64'h1000, 32'h33, 32'h0000_8067, 2'b11, 1, 1, 1, 0);
        fire;
        checks++; if (b.redirect_valid !== 1'b0) begin errors++; $display("FAIL nr_jalr got %b want 0", b.redirect_valid); end
        checks++; if (b.redirect_count !== exp_cnt) begin errors++; $display("FAIL nr_count got %h want %h", b.redirect_count, exp_cnt); end
    endtask

    task test_jal_target;
        offer(64'h1000, 32'h33, 32'h0080_006f, 2'b11, 1, 1, 1, 64'h2000);
        fire;
        exp_cnt = 6;
        checks++; if (obs !== {1'b1, 1'b1, 2'd3, 1'b1, 64'h100c}) begin errors++; $display("FAIL jt_out got %h want 1_1_3_1_100c", obs); end
        offer(64'h1000, 32'h33, 32'h0080_006f, 2'b11, 1, 1, 1, 64'h100c);
        fire;
        checks++; if (b.redirect_valid !== 1'b0) begin errors++; $display("FAIL jt_match got %b want 0", b.redirect_valid); end
        checks++; if (b.redirect_count !== exp_cnt) begin errors++; $display("FAIL jt_count got %h want %h", b.redirect_count, exp_cnt); end
    endtask

    task test_backpressure;
        offer(64'h8000_0004, 32'h33, 32'h33, 2'b11, 1, 1, 1, 0);
        fire;
        exp_cnt = 7;
        b.redirect_ready = 0;
        offer(64'h1000, 32'h0100_006f, 32'h33, 2'b11, 0, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if (b.fetch_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", b.fetch_ready); end
            step;
            checks++; if (obs !== {1'b1, 1'b0, 2'd1, 1'b1, 64'h8000_0008}) begin errors++; $display("FAIL bp_hold got %h want 1_0_1_1_80000008", obs); end
        end
        b.redirect_ready = 1;
        #1;
        checks++; if (b.fetch_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", b.fetch_ready); end
        fire;
        exp_cnt = 8;
        checks++; if (obs !== {1'b1, 1'b1, 2'd2, 1'b0, 64'h1010}) begin errors++; $display("FAIL bp_next got %h want 1_1_2_0_1010", obs); end
        checks++; if (b.redirect_count !== exp_cnt) begin errors++; $display("FAIL bp_count got %h want %h", b.redirect_count, exp_cnt); end
        step;
        checks++; if (b.redirect_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", b.redirect_valid); end
    endtask

    task test_flush;
        offer(64'h8000_0004, 32'h33, 32'h33, 2'b11, 1, 1, 1, 0);
        fire;
        exp_cnt = 9;
        b.flush = 1;
        offer(64'h1000, 32'h0100_006f, 32'h33, 2'b11, 0, 0, 0, 0);
        #1;
        checks++; if (b.fetch_ready !== 1'b0) begin errors++; $display("FAIL fl_ready got %b want 0", b.fetch_ready); end
        fire;
        b.flush = 0;
        checks++; if (b.redirect_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %b want 0", b.redirect_valid); end
        checks++; if (b.redirect_count !== exp_cnt) begin errors++; $display("FAIL fl_count got %h want %h", b.redirect_count, exp_cnt); end
    endtask

    task test_reset_mid;
        offer(64'h1000, 32'h0100_006f, 32'h33, 2'b11, 0, 0, 0, 0);
        fire;
        exp_cnt = 10;
        checks++; if (b.redirect_count !== exp_cnt) begin errors++; $display("FAIL rm_pre got %h want %h", b.redirect_count, exp_cnt); end
        reset = 1;
        step;
        checks++; if (b.fetch_ready !== 1'b0) begin errors++; $display("FAIL rm_ready got %b want 0", b.fetch_ready); end
        reset = 0;
        #1;
        exp_cnt = 0;
        checks++; if (obs !== 69'd0) begin errors++; $display("FAIL rm_out got %h want 0", obs); end
        checks++; if (b.redirect_count !== exp_cnt) begin errors++; $display("FAIL rm_count got %h want 0", b.redirect_count); end
    endtask

    task test_back_to_back_saturate;
        dut.count = 32'hFFFF_FFFD;
        offer(64'h8000_0004, 32'h33, 32'h33, 2'b11, 1, 1, 1, 0);
        step;
        checks++; if ({b.redirect_valid, b.redirect_count} !== {1'b1, 32'hFFFF_FFFE}) begin errors++; $display("FAIL sat_1 got %h want 1fffffffe", {b.redirect_valid, b.redirect_count}); end
        step;
        checks++; if ({b.redirect_valid, b.redirect_count} !== {1'b1, 32'hFFFF_FFFF}) begin errors++; $display("FAIL sat_2 got %h want 1ffffffff", {b.redirect_valid, b.redirect_count}); end
        step;
        b.fetch_valid = 0;
        checks++; if ({b.redirect_valid, b.redirect_count} !== {1'b1, 32'hFFFF_FFFF}) begin errors++; $display("FAIL sat_hold got %h want 1ffffffff", {b.redirect_valid, b.redirect_count}); end
        step;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_false_taken;
        test_jal_missed;
        test_no_redirect;
        test_jal_target;
        test_backpressure;
        test_flush;
        test_reset_mid;
        test_back_to_back_saturate;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_presolve_nwide.md
# branch_presolve_nwide

Registered, parametrised-width fetch-stage pre-resolver. It predecodes every slot of an N-wide fetch pack and corrects the branch predictor before decode: it cancels a "taken" prediction on a non-control slot and redirects JALs the predictor missed or mispointed. It sits between the fetch buffer and the frontend redirect mux. Redirects leave through a one-entry output register with a valid/ready handshake, which back-pressures fetch.

## Interface
- FETCH_WIDTH, 2, instructions per pack; power of two, 1..8
- XLEN, 64, PC width
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- io_i_flush  in  1  drop held redirect; highest priority
- io_i_fetch_pack_valid  in  1  pack offered
- io_o_fetch_pack_ready  out  1  pack accepted when valid & ready
- io_i_fetch_pack_valids  in  FETCH_WIDTH  per-slot valid, bit i = slot i
- io_i_fetch_pack_pc  in  XLEN  pack PC
- io_i_fetch_pack_insts  in  32*FETCH_WIDTH  slot i at [32i+31:32i]
- io_i_fetch_pack_branch_predict_pack_valid  in  1  prediction present
- io_i_fetch_pack_branch_predict_pack_select  in  max(1,log2 FETCH_WIDTH)  predicted slot
- io_i_fetch_pack_branch_predict_pack_taken  in  1  predicted taken
- io_i_fetch_pack_branch_predict_pack_target  in  XLEN  predicted target
- io_o_branch_presolve_pack_valid  out  1  redirect held
- io_i_branch_presolve_pack_ready  in  1  consumer takes redirect
- io_o_branch_presolve_pack_taken  out  1  1 = JAL redirect, 0 = sequential fix-up
- io_o_branch_presolve_pack_pc  out  XLEN  redirect PC
- io_o_branch_presolve_pack_kind  out  2  1 FALSE_TAKEN, 2 JAL_MISSED, 3 JAL_TARGET
- io_o_branch_presolve_pack_slot  out  max(1,log2 FETCH_WIDTH)  originating slot
- io_o_redirect_count  out  32  saturating count of stored redirects

## Operation
- Alignment: base = pc with the low log2(4*FETCH_WIDTH) bits cleared. pc_i = base + 4i.
- Predecode, slot i, only when valid bit i = 1:
  - BR: opcode 1100011
  - JAL: opcode 1101111
  - JALR: opcode 1100111
  - Control = BR | JAL | JALR
- JAL immediate: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, sign-extended to XLEN. The target is pc_i + imm, modulo 2^XLEN.
- Predicted slot s applies only when predict valid & taken; otherwise there is no predicted slot.
- Slot evaluation: scan slots 0..W-1 in order and act on the first hit. Slots after s are never examined.
  - Slot i < s (or any slot, if there is no prediction) that is a valid JAL -> JAL_MISSED; pc = JAL target; taken = 1.
  - Slot i = s that is invalid or not Control -> FALSE_TAKEN; pc = base + 4(s+1), full XLEN add; taken = 0.
  - Slot i = s that is a JAL whose predicted target differs from the computed target -> JAL_TARGET; pc = computed target; taken = 1.
  - Slot i = s that is BR, JALR, or a JAL with a matching target -> no redirect.
- An accepted pack that produces no redirect is consumed silently.
- State machine EMPTY/FULL over the output register:
  - EMPTY + accept with redirect -> FULL
  - FULL + consumer ready + accept with redirect -> FULL, with the new contents
  - FULL + consumer ready + no new redirect -> EMPTY
  - FULL + consumer not ready -> FULL, all outputs held stable
- io_o_fetch_pack_ready = !reset & !io_i_flush & (EMPTY | io_i_branch_presolve_pack_ready).
- Flush: the next state is EMPTY. No pack is accepted in the flush cycle. The counter is unaffected.
- Counter: +1 on each accepted pack that produces a redirect. It saturates at 0xFFFFFFFF and is cleared only by reset.

## Timing
- Reset values:
  - valid, taken, pc, kind, slot = 0
  - count = 0
  - io_o_fetch_pack_ready = 0 while reset is high; it is 1 in the first cycle after reset, provided flush is low.
- Latency: a redirect is visible exactly 1 cycle after its pack is accepted. There is no combinational path from the input pack to the outputs.
- Handshake: the output is consumed on valid & ready. Back-to-back redirects are possible at 1 per cycle.
- Simultaneous flush and accept: flush wins and the pack is dropped.
- Simultaneous flush and consumer ready: flush wins and the state is EMPTY.
- Reset mid-operation: the held redirect and the count are both lost.

## Test plan
- FETCH_WIDTH=2, pc=0x80000004, slots 0x00000033/0x00000033, predict taken select=1 -> next cycle: valid=1, pc=0x80000008, kind=1, taken=0, slot=1, count=1. FETCH_WIDTH=4, pc=0x1000, select=3, non-control slot -> pc=0x1010.
- pc=0x1000, slot0=0x0100006f (JAL +16), no prediction -> pc=0x1010, kind=2, taken=1, slot=0.
- Slot1=0x00000063 (BEQ), predict taken select=1 -> valid stays 0, count unchanged, ready stays 1.
- pc=0x1000, slot1=0x0080006f, predicted target 0x2000 -> pc=0x100C, kind=3, slot=1. With predicted target 0x100C -> no redirect.
- Held redirect with consumer ready=0 for 3 cycles -> io_o_fetch_pack_ready=0 and outputs stable. Ready=1 -> consumed, and a redirecting pack offered in the same cycle is accepted and appears the next cycle.
- Flush while FULL -> valid=0 the next cycle, count preserved. Reset while FULL -> all outputs 0 and count=0. 0xFFFFFFFF redirects -> count holds at 0xFFFFFFFF.
